// File: rtl/ps2_kbd_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame constants and
// the per-bit frame lookup used by the transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam int         FRAME_BITS = 11;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Line value for frame position idx (0 = start, 1..8 = data LSB first,
    // 9 = parity, 10 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic r;
        case (idx)
            4'd0:    r = START_BIT;
            4'd9:    r = odd_parity(b);
            4'd10:   r = STOP_BIT;
            default: r = b[3'(idx - 4'd1)];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Valid/ready request channel carrying one scancode and its break flag.
interface ps2_kbd_tx_if;
    logic       send_valid;
    logic       send_ready;
    logic [7:0] send_data;
    logic       send_break;

    modport master (output send_valid, output send_data, output send_break,
                    input  send_ready);
    modport slave  (input  send_valid, input  send_data, input  send_break,
                    output send_ready);
endinterface

// File: rtl/ps2_kbd_tx_half_tick.sv
// Half-period timebase: counts 0..CLK_DIV-1 and pulses tick_o on the last
// count. Synchronous clear holds the phase at 0.
module ps2_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: serialises one scancode (optionally
// preceded by an F0 break frame) as 11-bit frames, then idles for a gap.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_kbd_tx_if.slave   send_if,
    output logic          busy,
    output logic          done,
    output logic          ps2_clk,
    output logic          ps2_data
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FRAME = FRAME;
    localparam logic [1:0] ST_GAP   = GAP;
    localparam int         GW       = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

    logic [1:0]    state_q,     state_d;
    logic [3:0]    bit_idx_q,   bit_idx_d;
    logic          low_q,       low_d;
    logic [7:0]    byte_q,      byte_d;
    logic [7:0]    pend_byte_q, pend_byte_d;
    logic          pend_q,      pend_d;
    logic [GW-1:0] gap_cnt_q,   gap_cnt_d;
    logic          clk_q,       clk_d;
    logic          data_q,      data_d;
    logic          done_q,      done_d;
    logic          tick;
    logic          accept;

    ps2_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    assign send_if.send_ready = (state_q == ST_IDLE);
    assign accept             = send_if.send_valid && send_if.send_ready;
    assign busy               = (state_q != ST_IDLE);
    assign done               = done_q;
    assign ps2_clk            = clk_q;
    assign ps2_data           = data_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        low_d       = low_q;
        byte_d      = byte_q;
        pend_byte_d = pend_byte_q;
        pend_d      = pend_q;
        gap_cnt_d   = gap_cnt_q;
        clk_d       = clk_q;
        data_d      = data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_FRAME;
                    bit_idx_d   = 4'd0;
                    low_d       = 1'b0;
                    byte_d      = send_if.send_break ? BREAK_CODE : send_if.send_data;
                    pend_byte_d = send_if.send_data;
                    pend_d      = send_if.send_break;
                    clk_d       = 1'b1;
                    data_d      = START_BIT;
                end
            end
            ST_FRAME: begin
                if (tick) begin
                    if (!low_q) begin
                        clk_d = 1'b0;
                        low_d = 1'b1;
                    end else if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                        low_d     = 1'b0;
                        clk_d     = 1'b1;
                        data_d    = 1'b1;
                    end else begin
                        // Data only moves at the start of a high phase.
                        bit_idx_d = bit_idx_q + 4'd1;
                        low_d     = 1'b0;
                        clk_d     = 1'b1;
                        data_d    = frame_bit(byte_q, bit_idx_q + 4'd1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GW'(GAP_HALVES - 1)) begin
                        if (pend_q) begin
                            state_d   = ST_FRAME;
                            bit_idx_d = 4'd0;
                            byte_d    = pend_byte_q;
                            pend_d    = 1'b0;
                            data_d    = START_BIT;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                clk_d   = 1'b1;
                data_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= 4'd0;
            low_q       <= 1'b0;
            byte_q      <= 8'h00;
            pend_byte_q <= 8'h00;
            pend_q      <= 1'b0;
            gap_cnt_q   <= '0;
            clk_q       <= 1'b1;
            data_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            low_q       <= low_d;
            byte_q      <= byte_d;
            pend_byte_q <= pend_byte_d;
            pend_q      <= pend_d;
            gap_cnt_q   <= gap_cnt_d;
            clk_q       <= clk_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: captures ps2_data on ps2_clk falls and
// compares bits, edge timing, busy/done behaviour against a vector table.
module tb_ps2_kbd_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, ps2_clk, ps2_data;

    ps2_kbd_tx_if sif ();

    ps2_kbd_tx #(.CLK_DIV(4), .GAP_HALVES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .send_if  (sif),
        .busy     (busy),
        .done     (done),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          brk;
        bit          inject;
        int          nbits;
        logic [21:0] bits;
        int          done_cyc;
        string       name;
    } vec_t;

    vec_t vecs[7];

    // Falls come 4 cycles after frame start, 8 cycles apart; a second frame
    // starts 104 cycles (22*4 + 16 gap) after the first.
    function automatic int exp_fall(input int k);
        return 5 + 8 * (k % 11) + 104 * (k / 11);
    endfunction

    int          r_nfalls, r_done_cyc, r_busy_err, r_fall_err, r_done_cnt, r_dchg_err;
    logic [21:0] r_bits;

    task automatic run_xfer(input logic [7:0] d, input bit brk, input bit inject);
        int   cyc;
        logic prev_clk, prev_data;
        r_nfalls = 0; r_done_cyc = -1; r_busy_err = 0; r_fall_err = 0;
        r_done_cnt = 0; r_dchg_err = 0; r_bits = '0;
        @(negedge clk);
        sif.send_valid = 1'b1;
        sif.send_data  = d;
        sif.send_break = brk;
        @(posedge clk);
        prev_clk = 1'b1; prev_data = 1'b1; cyc = 0;
        while (cyc < 400 && (r_done_cyc < 0 || cyc < r_done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) sif.send_valid = 1'b0;
            if (inject && cyc == 20) begin
                sif.send_valid = 1'b1;
                sif.send_data  = 8'h55;
                sif.send_break = 1'b0;
            end
            if (inject && cyc == 21) begin
                sif.send_valid = 1'b0;
                if (sif.send_ready) r_busy_err++;
            end
            if (prev_clk && !ps2_clk) begin
                if (r_nfalls < 22) r_bits[r_nfalls] = ps2_data;
                if (cyc != exp_fall(r_nfalls)) r_fall_err++;
                r_nfalls++;
            end
            if (!ps2_clk && ps2_data !== prev_data) r_dchg_err++;
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
                if (busy || !sif.send_ready) r_busy_err++;
            end else if (r_done_cyc < 0 && !busy) begin
                r_busy_err++;
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        run_xfer(v.data, v.brk, v.inject);
        check({v.name, "_nfalls"},   32'(r_nfalls),   32'(v.nbits));
        check({v.name, "_bits"},     32'(r_bits),     32'(v.bits));
        check({v.name, "_done_cyc"}, 32'(r_done_cyc), 32'(v.done_cyc));
        check({v.name, "_done_cnt"}, 32'(r_done_cnt), 32'd1);
        check({v.name, "_busy_err"}, 32'(r_busy_err), 32'd0);
        check({v.name, "_fall_err"}, 32'(r_fall_err), 32'd0);
        check({v.name, "_dchg_err"}, 32'(r_dchg_err), 32'd0);
    endtask

    initial begin
        int   falls, guard, extra_falls, low_seen;
        logic pclk;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 11, 22'h000438, 105, "byte_1c"};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 11, 22'h000600, 105, "par_00"};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 11, 22'h0007FE, 105, "par_ff"};
        vecs[3] = '{8'h01, 1'b0, 1'b0, 11, 22'h000402, 105, "par_01"};
        vecs[4] = '{8'h1C, 1'b1, 1'b0, 22, 22'h21C7E0, 209, "break_1c"};
        vecs[5] = '{8'h1C, 1'b0, 1'b1, 11, 22'h000438, 105, "reject_55"};
        vecs[6] = '{8'h2A, 1'b0, 1'b0, 11, 22'h000454, 105, "post_rst_2a"};

        sif.send_valid = 1'b0;
        sif.send_data  = 8'h00;
        sif.send_break = 1'b0;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ps2_clk", 32'(ps2_clk),        32'd1);
        check("rst_ps2_data", 32'(ps2_data),      32'd1);
        check("rst_ready",   32'(sif.send_ready), 32'd1);
        check("rst_busy",    32'(busy),           32'd0);
        check("rst_done",    32'(done),           32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ps2_clk", 32'(ps2_clk),  32'd1);
        check("idle_ps2_data", 32'(ps2_data), 32'd1);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Mid-frame reset while ps2_clk is low during bit 5.
        @(negedge clk);
        sif.send_valid = 1'b1;
        sif.send_data  = 8'h1C;
        sif.send_break = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sif.send_valid = 1'b0;
        falls = 0; guard = 0; pclk = ps2_clk;
        while (falls < 6 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (pclk && !ps2_clk) falls++;
            pclk = ps2_clk;
        end
        check("midrst_reach_bit5", 32'(falls), 32'd6);
        low_seen = (ps2_clk == 1'b0) ? 1 : 0;
        check("midrst_clk_low_before", 32'(low_seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ps2_clk",  32'(ps2_clk),        32'd1);
        check("midrst_ps2_data", 32'(ps2_data),       32'd1);
        check("midrst_ready",    32'(sif.send_ready), 32'd1);
        check("midrst_busy",     32'(busy),           32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        extra_falls = 0; pclk = ps2_clk;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (pclk && !ps2_clk) extra_falls++;
            if (!ps2_clk || !ps2_data || busy) extra_falls++;
            pclk = ps2_clk;
        end
        check("midrst_quiet_after", 32'(extra_falls), 32'd0);

        apply_vec(vecs[6]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
Name: ps2_kbd_tx

Overview:
Device-side PS/2 keyboard transmitter for simulation.
- Takes one scancode byte from a valid/ready handshake, with an optional F0 break prefix.
- Serialises it as standard 11-bit PS/2 frames on ps2_clk/ps2_data.
- Drives the keyboard receiver and scancode-lookup chain in the sim top.
- Generates PS/2 clocking itself from the system clock.

Parameters:
- CLK_DIV, 4, system-clock cycles per PS/2 half-period (legal range >= 2).
- GAP_HALVES, 4, idle half-periods inserted after every frame, lines high (legal range >= 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- send_valid  in  1  request to transmit send_data.
- send_ready  out  1  block idle and able to accept.
- send_data  in  8  scancode byte.
- send_break  in  1  sampled with send_data; 1 = send F0 frame first, then send_data frame.
- busy  out  1  high from acceptance until the final gap completes.
- done  out  1  one-cycle pulse on the cycle the block returns to IDLE.
- ps2_clk  out  1  PS/2 clock; idles high.
- ps2_data  out  1  PS/2 data; idles high.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - ps2_clk=1, ps2_data=1, send_ready=1, busy=0, done=0.
  - State=IDLE; half-period counter, bit index and pending-byte register cleared.
- Acceptance: send_valid && send_ready at a clock edge latches send_data and send_break.
  - First frame byte = F0 if send_break, else send_data.
  - send_ready=0 and busy=1 from the next cycle.
- send_valid while send_ready=0 is ignored; no queueing.
- States: IDLE -> FRAME -> GAP -> (FRAME again if a second byte is pending) -> IDLE.
- FRAME:
  - 11 bits, index 0..10: start 0, data b0..b7 LSB first, parity = ~^byte (odd), stop 1.
  - Each bit = high phase of CLK_DIV cycles, then low phase of CLK_DIV cycles.
  - ps2_data changes only on the first cycle of a high phase.
  - ps2_data is stable across the falling edge; the receiver samples on ps2_clk fall.
  - First high phase (start bit) begins the cycle after acceptance.
  - Frame length = 22*CLK_DIV cycles.
- GAP:
  - Entered after the low phase of bit 10; ps2_clk=1, ps2_data=1 for GAP_HALVES*CLK_DIV cycles.
  - If a second byte is pending (break case), the next FRAME starts on the following cycle using send_data.
  - Otherwise go to IDLE: done=1 for one cycle, send_ready=1, busy=0 on that same cycle.
- Latencies:
  - Single byte, acceptance to done = (22+GAP_HALVES)*CLK_DIV + 1 cycles.
  - Break sequence = 2*(22+GAP_HALVES)*CLK_DIV + 1 cycles.
- Counters:
  - Half-period counter runs 0..CLK_DIV-1 and wraps, producing a phase tick.
  - Bit index is 4 bits, 0..10, and must never exceed 10.
- Lines are driven with plain push-pull drive; no host-inhibit or bidirectional support.

Decomposition:
- Shared package ps2_pkg:
  - State enum {IDLE, FRAME, GAP}.
  - Constants BREAK_CODE=8'hF0, FRAME_BITS=11, START_BIT=0, STOP_BIT=1.
  - Odd-parity function.
- One sub-module, ps2_half_tick: CLK_DIV counter with sync clear and tick output, reused by a future receiver model.

Test Plan:
- Reset idle: hold rst_n=0 five cycles -> ps2_clk=1, ps2_data=1, send_ready=1, busy=0.
- Single byte, CLK_DIV=4, send 8'h1C -> bits 0,0,0,1,1,1,0,0,0,0(parity),1 sampled on falling edges. First fall 4 cycles after start; done 105 cycles after acceptance.
- Parity, send 8'h00 -> parity bit 1; send 8'hFF -> parity bit 1; send 8'h01 -> parity bit 0.
- Break, send_break=1 with 8'h1C -> frame F0 (data 0,0,0,0,1,1,1,1, parity 1), gap of 16 cycles high, then 1C frame. busy stays high throughout; single done at cycle 209.
- Busy reject: pulse send_valid with 8'h55 mid-frame -> ignored. Captured stream unchanged; next byte accepted only after done.
- Mid-frame reset: assert rst_n=0 at bit 5 -> both lines high in the same cycle, no further falling edges. After release, send 8'h2A transmits a clean full frame.
